// File: rtl/otter_decode_stage.sv
// otter_decode_stage: decodes one RV32I(M) instruction per handshake into a registered control bundle.
module otter_decode_stage #(
  parameter int XLEN = 32,
  parameter int EN_MEXT = 0,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      IN_INSTR,
  input  logic [XLEN-1:0]  IN_PC,
  input  logic             FLUSH,
  input  logic             INT_REQ,
  input  logic             INT_EN,
  input  logic             OUT_READY,
  output logic             OUT_VALID,
  output logic [XLEN-1:0]  OUT_PC,
  output logic             OUT_ALU_SRCA,
  output logic [1:0]       OUT_ALU_SRCB,
  output logic [4:0]       OUT_ALU_FUN,
  output logic [1:0]       OUT_RF_WR_SEL,
  output logic [2:0]       OUT_PCSOURCE,
  output logic             OUT_RF_WE,
  output logic             OUT_MEM_WE,
  output logic             OUT_MEM_RE,
  output logic             OUT_IS_BRANCH,
  output logic             OUT_INT_TAKEN,
  output logic             OUT_ILLEGAL,
  output logic [2:0]       OUT_BR_TYPE,
  output logic [CNT_W-1:0] OUT_DEC_CNT
);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [31:0] MRET    = 32'h30200073;

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic acc, int_now, kill, mul;
  logic srca_d, rfwe_d, mwe_d, mre_d, br_d, ill_d;
  logic [1:0] srcb_d, wrsel_d;
  logic [4:0] fun_d;
  logic [2:0] pcs_d;
  logic [21:0] dec_d, dec_q;
  logic valid_d, valid_q, pend_d, pend_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [XLEN-1:0] pc_q;

  assign op = IN_INSTR[6:0];
  assign rd = IN_INSTR[11:7];
  assign f3 = IN_INSTR[14:12];
  assign f7 = IN_INSTR[31:25];
  assign mul = (EN_MEXT != 0) && (f7 == 7'b0000001);

  assign IN_READY = !RST && !FLUSH && (!valid_q || OUT_READY);
  assign acc = IN_VALID && IN_READY;
  assign int_now = pend_q || (INT_REQ && INT_EN);
  assign kill = ill_d || int_now;

  // raw per-opcode decode before interrupt/illegal overrides
  always_comb begin
    srca_d = 1'b0;
    srcb_d = 2'd0;
    fun_d = 5'd0;
    wrsel_d = 2'd3;
    pcs_d = 3'd0;
    rfwe_d = 1'b0;
    mwe_d = 1'b0;
    mre_d = 1'b0;
    br_d = 1'b0;
    ill_d = 1'b0;
    case (op)
      OP_LUI: begin srca_d = 1'b1; fun_d = 5'b01001; rfwe_d = 1'b1; end
      OP_AUIPC: begin srca_d = 1'b1; srcb_d = 2'd3; rfwe_d = 1'b1; end
      OP_JAL: begin wrsel_d = 2'd0; pcs_d = 3'd3; rfwe_d = 1'b1; end
      OP_JALR: begin srcb_d = 2'd1; wrsel_d = 2'd0; pcs_d = 3'd1; rfwe_d = 1'b1; end
      OP_BR: begin br_d = 1'b1; ill_d = f3[2:1] == 2'b01; end
      OP_LOAD: begin srcb_d = 2'd1; wrsel_d = 2'd2; rfwe_d = 1'b1; mre_d = 1'b1; end
      OP_STORE: begin srcb_d = 2'd2; mwe_d = 1'b1; end
      OP_IMM: begin srcb_d = 2'd1; rfwe_d = 1'b1; fun_d = {1'b0, (f3 == 3'b101) && f7[5], f3}; end
      OP_REG: begin
        rfwe_d = 1'b1;
        fun_d = mul ? {2'b10, f3} : {1'b0, f7[5], f3};
        ill_d = !(f7 == 7'b0000000 || f7 == 7'b0100000 || mul);
      end
      OP_SYS: begin
        fun_d = 5'b01001;
        wrsel_d = 2'd1;
        rfwe_d = f3 != 3'b000;
        pcs_d = (IN_INSTR == MRET) ? 3'd5 : 3'd0;
        ill_d = f3 == 3'b000 && IN_INSTR != MRET;
      end
      default: ill_d = 1'b1;
    endcase
  end

  assign dec_d = {srca_d, srcb_d, fun_d, wrsel_d,
                  int_now ? 3'd4 : ill_d ? 3'd6 : pcs_d,
                  rfwe_d && rd != 5'd0 && !kill, mwe_d && !kill, mre_d && !kill,
                  br_d && !int_now, int_now, ill_d && !int_now, f3};

  assign valid_d = acc || (valid_q && !FLUSH && !OUT_READY);
  assign pend_d = !acc && (pend_q || (INT_REQ && INT_EN));
  assign cnt_d = cnt_q + CNT_W'(acc);

  // output register: loads on accept, otherwise holds; valid/pending/count track every cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q <= '0;
      pc_q <= '0;
      dec_q <= '0;
    end else begin
      valid_q <= valid_d;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      if (acc) begin
        pc_q <= IN_PC;
        dec_q <= dec_d;
      end
    end
  end

  assign OUT_VALID = valid_q;
  assign OUT_PC = pc_q;
  assign OUT_DEC_CNT = cnt_q;
  assign {OUT_ALU_SRCA, OUT_ALU_SRCB, OUT_ALU_FUN, OUT_RF_WR_SEL, OUT_PCSOURCE, OUT_RF_WE,
          OUT_MEM_WE, OUT_MEM_RE, OUT_IS_BRANCH, OUT_INT_TAKEN, OUT_ILLEGAL, OUT_BR_TYPE} = dec_q;
endmodule

// File: tb/tb_otter_decode_stage.sv
// tb_otter_decode_stage: directed vectors against a behavioural decode model, two parameterisations side by side.
module tb_otter_decode_stage;
  typedef struct packed {
    logic srca; logic [1:0] srcb; logic [4:0] fun; logic [1:0] wrsel; logic [2:0] pcs;
    logic rfwe, mwe, mre, isbr, intk, ill; logic [2:0] brt;
  } dec_t;

  logic CLK = 1'b0, RST, IN_VALID, FLUSH, INT_REQ, INT_EN, OUT_READY;
  logic [31:0] IN_INSTR, IN_PC;
  always #5 CLK = ~CLK;

  logic a_rdy, a_valid, a_srca, a_rfwe, a_mwe, a_mre, a_br, a_intk, a_ill;
  logic [31:0] a_pc; logic [1:0] a_srcb, a_wrsel; logic [4:0] a_fun; logic [2:0] a_pcs, a_brt;
  logic [15:0] a_cnt;
  logic b_rdy, b_valid, b_srca, b_rfwe, b_mwe, b_mre, b_br, b_intk, b_ill;
  logic [31:0] b_pc; logic [1:0] b_srcb, b_wrsel; logic [4:0] b_fun; logic [2:0] b_pcs, b_brt;
  logic [2:0] b_cnt;
  dec_t a_dec, b_dec;
  assign a_dec = {a_srca, a_srcb, a_fun, a_wrsel, a_pcs, a_rfwe, a_mwe, a_mre, a_br, a_intk, a_ill, a_brt};
  assign b_dec = {b_srca, b_srcb, b_fun, b_wrsel, b_pcs, b_rfwe, b_mwe, b_mre, b_br, b_intk, b_ill, b_brt};

  otter_decode_stage #(.XLEN(32), .EN_MEXT(0), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(a_rdy), .IN_INSTR(IN_INSTR), .IN_PC(IN_PC),
    .FLUSH(FLUSH), .INT_REQ(INT_REQ), .INT_EN(INT_EN), .OUT_READY(OUT_READY), .OUT_VALID(a_valid),
    .OUT_PC(a_pc), .OUT_ALU_SRCA(a_srca), .OUT_ALU_SRCB(a_srcb), .OUT_ALU_FUN(a_fun),
    .OUT_RF_WR_SEL(a_wrsel), .OUT_PCSOURCE(a_pcs), .OUT_RF_WE(a_rfwe), .OUT_MEM_WE(a_mwe),
    .OUT_MEM_RE(a_mre), .OUT_IS_BRANCH(a_br), .OUT_INT_TAKEN(a_intk), .OUT_ILLEGAL(a_ill),
    .OUT_BR_TYPE(a_brt), .OUT_DEC_CNT(a_cnt));

  otter_decode_stage #(.XLEN(32), .EN_MEXT(1), .CNT_W(3)) dut_b (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(b_rdy), .IN_INSTR(IN_INSTR), .IN_PC(IN_PC),
    .FLUSH(FLUSH), .INT_REQ(INT_REQ), .INT_EN(INT_EN), .OUT_READY(OUT_READY), .OUT_VALID(b_valid),
    .OUT_PC(b_pc), .OUT_ALU_SRCA(b_srca), .OUT_ALU_SRCB(b_srcb), .OUT_ALU_FUN(b_fun),
    .OUT_RF_WR_SEL(b_wrsel), .OUT_PCSOURCE(b_pcs), .OUT_RF_WE(b_rfwe), .OUT_MEM_WE(b_mwe),
    .OUT_MEM_RE(b_mre), .OUT_IS_BRANCH(b_br), .OUT_INT_TAKEN(b_intk), .OUT_ILLEGAL(b_ill),
    .OUT_BR_TYPE(b_brt), .OUT_DEC_CNT(b_cnt));

  int checks = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dec(input string t, input dec_t a, input dec_t e);
    chk({t, "_srca"}, 32'(a.srca), 32'(e.srca));
    chk({t, "_srcb"}, 32'(a.srcb), 32'(e.srcb));
    chk({t, "_fun"}, 32'(a.fun), 32'(e.fun));
    chk({t, "_wrsel"}, 32'(a.wrsel), 32'(e.wrsel));
    chk({t, "_pcsource"}, 32'(a.pcs), 32'(e.pcs));
    chk({t, "_rf_we"}, 32'(a.rfwe), 32'(e.rfwe));
    chk({t, "_mem_we"}, 32'(a.mwe), 32'(e.mwe));
    chk({t, "_mem_re"}, 32'(a.mre), 32'(e.mre));
    chk({t, "_is_branch"}, 32'(a.isbr), 32'(e.isbr));
    chk({t, "_int_taken"}, 32'(a.intk), 32'(e.intk));
    chk({t, "_illegal"}, 32'(a.ill), 32'(e.ill));
    chk({t, "_br_type"}, 32'(a.brt), 32'(e.brt));
  endtask

  function automatic dec_t model_dec(input logic [31:0] ins, input bit mext, input bit intr);
    dec_t d;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit lui, auipc, jal, jalr, br, ld, st, opi, opr, sys, mret, mop, known;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    lui = op == 7'h37; auipc = op == 7'h17; jal = op == 7'h6F; jalr = op == 7'h67;
    br = op == 7'h63; ld = op == 7'h03; st = op == 7'h23; opi = op == 7'h13;
    opr = op == 7'h33; sys = op == 7'h73;
    known = lui | auipc | jal | jalr | br | ld | st | opi | opr | sys;
    mret = ins == 32'h30200073;
    mop = opr && f7 == 7'd1 && mext;
    d = '0;
    if (mop) d.fun = {2'b10, f3};
    else if (opr) d.fun = {1'b0, f7[5], f3};
    else if (opi) d.fun = (f3 == 3'd5) ? {1'b0, f7[5], f3} : {2'b00, f3};
    else if (lui || sys) d.fun = 5'b01001;
    d.srca = lui || auipc;
    d.srcb = st ? 2'd2 : (ld || jalr || opi) ? 2'd1 : auipc ? 2'd3 : 2'd0;
    d.wrsel = (jal || jalr) ? 2'd0 : sys ? 2'd1 : ld ? 2'd2 : 2'd3;
    d.rfwe = (lui || auipc || jal || jalr || ld || opi || opr || (sys && f3 != 0)) && ins[11:7] != 0;
    d.mwe = st; d.mre = ld; d.isbr = br; d.brt = f3;
    d.pcs = jal ? 3'd3 : jalr ? 3'd1 : mret ? 3'd5 : 3'd0;
    d.ill = !known || (opr && !(f7 == 7'h00 || f7 == 7'h20 || mop)) ||
            (br && (f3 == 3'd2 || f3 == 3'd3)) || (sys && f3 == 0 && !mret);
    if (d.ill) begin d.rfwe = 0; d.mwe = 0; d.mre = 0; d.pcs = 3'd6; end
    if (intr) begin d.pcs = 3'd4; d.rfwe = 0; d.mwe = 0; d.mre = 0; d.ill = 0; d.isbr = 0; d.intk = 1; end
    return d;
  endfunction

  bit m_valid, m_pend, m_rdy, m_intr;
  int m_cnt;
  logic [31:0] m_pc;
  dec_t m_a, m_b;

  always @(posedge CLK) begin
    m_rdy = !RST && !FLUSH && (!m_valid || OUT_READY);
    if (RST) begin
      m_valid = 0; m_pend = 0; m_cnt = 0; m_pc = 0; m_a = '0; m_b = '0;
    end else if (IN_VALID && m_rdy) begin
      m_intr = m_pend || (INT_REQ && INT_EN);
      m_a = model_dec(IN_INSTR, 0, m_intr);
      m_b = model_dec(IN_INSTR, 1, m_intr);
      m_pc = IN_PC; m_valid = 1; m_pend = 0; m_cnt++;
    end else begin
      if (FLUSH || OUT_READY) m_valid = 0;
      if (INT_REQ && INT_EN) m_pend = 1;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("a_in_ready", 32'(a_rdy), 32'(!RST && !FLUSH && (!m_valid || OUT_READY)));
      chk("b_in_ready", 32'(b_rdy), 32'(!RST && !FLUSH && (!m_valid || OUT_READY)));
      chk("a_out_valid", 32'(a_valid), 32'(m_valid));
      chk("b_out_valid", 32'(b_valid), 32'(m_valid));
      chk("a_dec_cnt", 32'(a_cnt), m_cnt & 32'hFFFF);
      chk("b_dec_cnt", 32'(b_cnt), m_cnt & 32'h7);
      if (m_valid) begin
        chk("a_out_pc", a_pc, m_pc);
        chk("b_out_pc", b_pc, m_pc);
        cmp_dec("a", a_dec, m_a);
        cmp_dec("b", b_dec, m_b);
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic send(input logic [31:0] ins);
    IN_VALID = 1; IN_INSTR = ins; IN_PC = IN_PC + 4;
    tick;
  endtask

  logic [31:0] vecs [15] = '{32'h12345537, 32'h00001517, 32'h000080E7, 32'h0002A303, 32'h0062A023,
                             32'h00208463, 32'h00209463, 32'h30529073, 32'h300022F3, 32'h00000073,
                             32'h0000007F, 32'h04310033, 32'h00310033, 32'h403100B3, 32'h4072F293};

  initial begin
    RST = 1; IN_VALID = 0; FLUSH = 0; INT_REQ = 0; INT_EN = 0; OUT_READY = 1;
    IN_INSTR = 0; IN_PC = 32'h100;
    tick;
    chk_en = 1;
    chk("rst_in_ready", 32'(a_rdy), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_cnt", 32'(a_cnt), 0);
    RST = 0;
    send(32'h003100B3); IN_VALID = 0;
    chk("add_valid", 32'(a_valid), 1);
    chk("add_fun", 32'(a_fun), 0);
    chk("add_srcb", 32'(a_srcb), 0);
    chk("add_wrsel", 32'(a_wrsel), 3);
    chk("add_rfwe", 32'(a_rfwe), 1);
    chk("add_cnt", 32'(a_cnt), 1);
    send(32'h40315093);
    OUT_READY = 0; IN_INSTR = 32'h00000013;
    repeat (3) begin
      tick;
      chk("srai_fun_held", 32'(a_fun), 32'b01101);
      chk("stall_in_ready", 32'(a_rdy), 0);
      chk("stall_cnt", 32'(a_cnt), 2);
    end
    OUT_READY = 1;
    send(32'h00000013);
    send(32'h023100B3);
    chk("mul_a_ill", 32'(a_ill), 1);
    chk("mul_a_pcs", 32'(a_pcs), 6);
    chk("mul_a_rfwe", 32'(a_rfwe), 0);
    chk("mul_b_fun", 32'(b_fun), 32'b10000);
    chk("mul_b_ill", 32'(b_ill), 0);
    for (int i = 0; i < 15; i++) send(vecs[i]);
    IN_VALID = 0;
    tick;
    chk("drain_valid", 32'(a_valid), 0);
    INT_EN = 1; INT_REQ = 1;
    tick;
    INT_REQ = 0;
    tick;
    send(32'h000000EF);
    chk("int_taken", 32'(a_intk), 1);
    chk("int_pcs", 32'(a_pcs), 4);
    chk("int_rfwe", 32'(a_rfwe), 0);
    chk("int_pc_kept", a_pc, IN_PC);
    send(32'h003100B3);
    chk("post_int_taken", 32'(a_intk), 0);
    INT_REQ = 1;
    send(32'h003100B3);
    INT_REQ = 0;
    chk("live_int_taken", 32'(a_intk), 1);
    send(32'h003100B3);
    chk("live_int_cleared", 32'(a_intk), 0);
    IN_VALID = 0; INT_REQ = 1;
    tick;
    INT_REQ = 0; FLUSH = 1; IN_VALID = 1; IN_INSTR = 32'h12345537;
    tick;
    chk("flush_no_accept", 32'(a_valid), 0);
    FLUSH = 0;
    send(32'h12345537);
    chk("flush_keeps_pend", 32'(a_intk), 1);
    INT_EN = 0;
    send(32'h30200073);
    chk("mret_pcs", 32'(a_pcs), 5);
    FLUSH = 1; OUT_READY = 0;
    tick;
    chk("mret_flush_valid", 32'(a_valid), 0);
    FLUSH = 0; OUT_READY = 1;
    send(32'h003100B3);
    FLUSH = 1;
    tick;
    chk("flush_and_ready_valid", 32'(a_valid), 0);
    FLUSH = 0;
    repeat (10) send(32'h00000013);
    send(32'h403100B3);
    OUT_READY = 0;
    tick;
    RST = 1;
    chk("rst_blocks_ready", 32'(a_rdy), 0);
    tick;
    chk("rst_stall_valid", 32'(a_valid), 0);
    chk("rst_stall_cnt", 32'(a_cnt), 0);
    chk("rst_stall_fun", 32'(a_fun), 0);
    chk("rst_stall_rfwe", 32'(a_rfwe), 0);
    chk("rst_stall_wrsel", 32'(a_wrsel), 0);
    chk("rst_stall_pc", a_pc, 0);
    RST = 0; OUT_READY = 1; IN_VALID = 0;
    tick;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
